// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - data-memory access stage with EX/MEM request handshake and MEM/WB register
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of issuing them.
module mem_access_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    input  logic        i_ctrl_valid,
    input  logic        i_ctrl_bubble,
    input  logic        i_ctrl_mem_read,
    input  logic        i_ctrl_mem_write,
    input  logic        i_ctrl_wb_en,
    input  logic [2:0]  i_ctrl_funct3,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_wb_pc,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;

    state_t      state, state_nxt;
    logic        live, mem_op, misaligned;
    logic        sz_byte, sz_half;
    logic [1:0]  byte_off;
    logic        granted, store_done, load_done, trap_done;
    logic [31:0] rdata_shift, load_val;

    assign live    = i_ctrl_valid & ~i_ctrl_bubble;
    assign mem_op  = live & (i_ctrl_mem_read | i_ctrl_mem_write);
    assign sz_byte = (i_ctrl_funct3[1:0] == 2'b00);
    assign sz_half = (i_ctrl_funct3[1:0] == 2'b01);

    // Sub-size low address bits are dropped, so a misaligned access degrades to its aligned lane.
    assign byte_off = sz_byte ? i_alu_result[1:0] :
                      sz_half ? {i_alu_result[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op & (sz_half ? i_alu_result[0] :
                                  (~sz_byte & (i_alu_result[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign o_dmem_req   = ((state == S_IDLE) & mem_op & ~misaligned) | (state == S_REQ);
    assign o_dmem_we    = i_ctrl_mem_write;
    assign o_dmem_addr  = {i_alu_result[31:2], 2'b00};
    assign o_dmem_wdata = sz_byte ? {4{i_store_data[7:0]}} :
                          sz_half ? {2{i_store_data[15:0]}} : i_store_data;
    assign o_dmem_bmask = sz_byte ? (4'b0001 << byte_off) :
                          sz_half ? (byte_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign granted    = o_dmem_req & i_dmem_gnt;
    assign store_done = granted & i_ctrl_mem_write;
    assign load_done  = (state == S_WAIT_RSP) & i_dmem_rvalid;
    assign trap_done  = (state == S_IDLE) & misaligned;
    assign o_stall    = mem_op & ~(store_done | load_done | trap_done);

    assign rdata_shift = i_dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        load_val = i_dmem_rdata;
        case (i_ctrl_funct3)
            3'b000:  load_val = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_val = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_val = {24'h0, rdata_shift[7:0]};
            3'b101:  load_val = {16'h0, rdata_shift[15:0]};
            default: load_val = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_REQ: begin
                if (o_dmem_req) begin
                    if (!i_dmem_gnt)
                        state_nxt = S_REQ;
                    else if (i_ctrl_mem_write)
                        state_nxt = S_IDLE;
                    else
                        state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: if (i_dmem_rvalid) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MEM/WB register: anything that is not a completing access or a live ALU op lands as a bubble.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_wb_valid   <= 1'b0;
            o_wb_en      <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_data    <= 32'd0;
            o_wb_pc      <= 32'd0;
            o_misaligned <= 1'b0;
        end else if (load_done || store_done || trap_done || (live && !mem_op)) begin
            o_wb_valid   <= 1'b1;
            o_wb_en      <= (load_done || (live && !mem_op)) ? i_ctrl_wb_en : 1'b0;
            o_wb_rd      <= i_rd;
            o_wb_data    <= load_done ? load_val :
                            (live && !mem_op) ? i_alu_result : 32'd0;
            o_wb_pc      <= i_pc;
            o_misaligned <= trap_done;
        end else begin
            o_wb_valid   <= 1'b0;
            o_wb_en      <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_data    <= 32'd0;
            o_wb_pc      <= 32'd0;
            o_misaligned <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk, rst_n;
    logic [31:0] pc, alu, sdata;
    logic [4:0]  rd;
    logic        valid, bubble, mrd, mwr, wb_en;
    logic [2:0]  f3;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  bmask;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        stall, wb_valid, wbo_en, mis;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_stage dut (
        .i_clk(clk), .i_reset(rst_n), .i_pc(pc), .i_alu_result(alu), .i_store_data(sdata),
        .i_rd(rd), .i_ctrl_valid(valid), .i_ctrl_bubble(bubble), .i_ctrl_mem_read(mrd),
        .i_ctrl_mem_write(mwr), .i_ctrl_wb_en(wb_en), .i_ctrl_funct3(f3),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_wdata(wdata),
        .o_dmem_bmask(bmask), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_stall(stall), .o_wb_valid(wb_valid), .o_wb_en(wbo_en), .o_wb_rd(wb_rd),
        .o_wb_data(wb_data), .o_wb_pc(wb_pc), .o_misaligned(mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, sdata, pc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mrd, mwr, wb_en, valid, bubble, gnt;
        logic        exp_req, exp_stall;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_bmask;
        logic        exp_wb_valid, exp_wb_en;
        logic [31:0] exp_wb_data;
        logic [4:0]  exp_wb_rd;
        logic [31:0] exp_wb_pc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        valid = 0; bubble = 0; mrd = 0; mwr = 0; wb_en = 0; f3 = 3'b000;
        alu = 0; sdata = 0; rd = 0; pc = 0; gnt = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] fn,
                           input logic [31:0] rd_word, input logic [31:0] exp);
        @(negedge clk);
        valid = 1; bubble = 0; mrd = 1; mwr = 0; wb_en = 1; f3 = fn; alu = a; rd = 5'd3;
        pc = 32'h80; gnt = 1; rvalid = 1; rdata = 32'hDEADBEEF;
        #1;
        chk({nm, "_req"}, {31'd0, req}, 1);
        chk({nm, "_stall_n"}, {31'd0, stall}, 1);
        chk({nm, "_addr"}, addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        chk({nm, "_wbv_n"}, {31'd0, wb_valid}, 0);
        @(negedge clk);
        gnt = 0; rvalid = 1; rdata = rd_word;
        #1;
        chk({nm, "_req_n1"}, {31'd0, req}, 0);
        chk({nm, "_stall_n1"}, {31'd0, stall}, 0);
        @(posedge clk); #1;
        chk({nm, "_wbv"}, {31'd0, wb_valid}, 1);
        chk({nm, "_wben"}, {31'd0, wbo_en}, 1);
        chk({nm, "_data"}, wb_data, exp);
        chk({nm, "_rd"}, {27'd0, wb_rd}, 3);
        chk({nm, "_mis"}, {31'd0, mis}, 0);
        @(negedge clk);
        set_idle();
    endtask

    vec_t vt[8];
    int   stall_cnt, req_cnt, wbv_cnt, wbv_cyc;
    logic [31:0] wbv_data;

    initial begin
        //        alu           sdata         pc        rd  f3    rd wr en v  b  g  req st addr          wdata         bmask   wbv en data          rd  pc
        vt[0] = '{32'h1234,     32'h0,        32'h10,   5,  3'd0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 1, 32'h1234,     5,  32'h10};
        vt[1] = '{32'h103,      32'hAB,       32'h14,   0,  3'd0, 0, 1, 0, 1, 0, 1, 1, 0, 32'h100,      32'hABABABAB, 4'b1000, 1, 0, 32'h0,        0,  32'h14};
        vt[2] = '{32'h202,      32'h1234CDEF, 32'h18,   0,  3'd1, 0, 1, 0, 1, 0, 1, 1, 0, 32'h200,      32'hCDEFCDEF, 4'b1100, 1, 0, 32'h0,        0,  32'h18};
        vt[3] = '{32'h300,      32'hDEADBEEF, 32'h1C,   0,  3'd2, 0, 1, 0, 1, 0, 1, 1, 0, 32'h300,      32'hDEADBEEF, 4'b1111, 1, 0, 32'h0,        0,  32'h1C};
        vt[4] = '{32'h401,      32'h55,       32'h20,   0,  3'd0, 0, 1, 0, 1, 0, 1, 1, 0, 32'h400,      32'h55555555, 4'b0010, 1, 0, 32'h0,        0,  32'h20};
        vt[5] = '{32'h500,      32'h77,       32'h24,   4,  3'd2, 0, 1, 1, 1, 1, 1, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0,        0,  32'h0};
        vt[6] = '{32'h99,       32'h0,        32'h28,   6,  3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0,        0,  32'h0};
        vt[7] = '{32'hFFFFFFFF, 32'h0,        32'h2C,   31, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 0, 32'hFFFFFFFF, 31, 32'h2C};

        set_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wbv", {31'd0, wb_valid}, 0);
        chk("rst_wben", {31'd0, wbo_en}, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_rd", {27'd0, wb_rd}, 0);
        chk("rst_pc", wb_pc, 0);
        chk("rst_mis", {31'd0, mis}, 0);
        chk("rst_req", {31'd0, req}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            alu = vt[i].alu; sdata = vt[i].sdata; pc = vt[i].pc; rd = vt[i].rd; f3 = vt[i].f3;
            mrd = vt[i].mrd; mwr = vt[i].mwr; wb_en = vt[i].wb_en; valid = vt[i].valid;
            bubble = vt[i].bubble; gnt = vt[i].gnt; rvalid = 0;
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vt[i].exp_req});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].exp_stall});
            if (vt[i].exp_req) begin
                chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vt[i].mwr});
                chk($sformatf("v%0d_addr", i), addr, vt[i].exp_addr);
                chk($sformatf("v%0d_wdata", i), wdata, vt[i].exp_wdata);
                chk($sformatf("v%0d_bmask", i), {28'd0, bmask}, {28'd0, vt[i].exp_bmask});
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_wbv", i), {31'd0, wb_valid}, {31'd0, vt[i].exp_wb_valid});
            chk($sformatf("v%0d_wben", i), {31'd0, wbo_en}, {31'd0, vt[i].exp_wb_en});
            chk($sformatf("v%0d_data", i), wb_data, vt[i].exp_wb_data);
            chk($sformatf("v%0d_rd", i), {27'd0, wb_rd}, {27'd0, vt[i].exp_wb_rd});
            chk($sformatf("v%0d_pc", i), wb_pc, vt[i].exp_wb_pc);
        end
        @(negedge clk);
        set_idle();

        do_load("lb",  32'h102, 3'b000, 32'h00800000, 32'hFFFFFF80);
        do_load("lbu", 32'h102, 3'b100, 32'h00800000, 32'h00000080);
        do_load("lh",  32'h202, 3'b001, 32'h80010000, 32'hFFFF8001);
        do_load("lhu", 32'h202, 3'b101, 32'h80010000, 32'h00008001);
        do_load("f3_011", 32'h104, 3'b011, 32'h5A5AA5A5, 32'h5A5AA5A5);

        // LW: grant withheld three cycles, data two cycles after grant.
        stall_cnt = 0; req_cnt = 0; wbv_cnt = 0; wbv_cyc = -1; wbv_data = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                valid = 1; mrd = 1; mwr = 0; wb_en = 1; f3 = 3'b010; alu = 32'h200; rd = 5'd9; pc = 32'h44;
            end else begin
                set_idle();
            end
            gnt = (c == 3);
            rvalid = (c == 5);
            rdata = (c == 5) ? 32'hCAFEF00D : 32'h0BADBAD0;
            #1;
            if (stall) stall_cnt++;
            if (req) req_cnt++;
            @(posedge clk); #1;
            if (wb_valid) begin
                wbv_cnt++;
                wbv_cyc = c;
                wbv_data = wb_data;
            end
        end
        chk("lw_slow_stalls", stall_cnt, 5);
        chk("lw_slow_reqs", req_cnt, 4);
        chk("lw_slow_wbcnt", wbv_cnt, 1);
        chk("lw_slow_wbcyc", wbv_cyc, 5);
        chk("lw_slow_data", wbv_data, 32'hCAFEF00D);

        // Reset while waiting for read data, then a late rvalid.
        @(negedge clk);
        valid = 1; mrd = 1; mwr = 0; wb_en = 1; f3 = 3'b010; alu = 32'h300; rd = 5'd7; gnt = 1;
        @(negedge clk);
        rst_n = 0;
        set_idle();
        #1;
        chk("rstmid_wbv", {31'd0, wb_valid}, 0);
        chk("rstmid_stall", {31'd0, stall}, 0);
        @(negedge clk);
        rst_n = 1;
        rvalid = 1; rdata = 32'h12345678;
        @(posedge clk); #1;
        chk("rstmid_late_wbv", {31'd0, wb_valid}, 0);
        chk("rstmid_late_data", wb_data, 0);
        @(negedge clk);
        set_idle();

`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        valid = 1; mrd = 1; mwr = 0; wb_en = 1; f3 = 3'b010; alu = 32'h101; rd = 5'd2; gnt = 1;
        #1;
        chk("mis_req", {31'd0, req}, 0);
        chk("mis_stall", {31'd0, stall}, 0);
        @(posedge clk); #1;
        chk("mis_wbv", {31'd0, wb_valid}, 1);
        chk("mis_wben", {31'd0, wbo_en}, 0);
        chk("mis_flag", {31'd0, mis}, 1);
        @(negedge clk);
        set_idle();
`else
        do_load("lw_mis", 32'h101, 3'b010, 32'h11223344, 32'h11223344);
        do_load("lh_mis", 32'h203, 3'b001, 32'h80010000, 32'hFFFF8001);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
